// File: rtl/vscpu_mem_responder.sv
// Memory responder for the VerySimpleCPU: word RAM, a small MMIO register file
// and a host loader that keeps the core in reset until the program is in RAM.
module vscpu_mem_responder #(
   parameter int               SIZE      = 14,
   parameter int               MEM_DEPTH = 1024,
   parameter logic [SIZE-1:0]  MMIO_BASE = 14'h3FF0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] addr_fromCPU,
   input  logic [31:0]     data_fromCPU,
   input  logic            wrEn,
   output logic [31:0]     data_toCPU,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [SIZE-1:0] ld_addr,
   input  logic [31:0]     ld_data,
   input  logic            ld_done,
   output logic            cpu_rst,
   output logic [31:0]     out_reg,
   output logic            halted
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

   state_t        state;
   logic [31:0]   mem [MEM_DEPTH];
   logic [31:0]   cycle_cnt;
   logic [31:0]   wr_cnt;
   logic [31:0]   rd_data;
   logic          cpu_in_ram;
   logic          cpu_in_mmio;
   logic          ld_in_ram;
   logic          cpu_wr;
   logic [3:0]    mmio_off;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [31:0]   ram_wdata;

   // The MMIO window is assumed 16-word aligned, so only the upper bits are compared.
   assign cpu_in_ram  = 32'(addr_fromCPU) < 32'(MEM_DEPTH);
   assign ld_in_ram   = 32'(ld_addr) < 32'(MEM_DEPTH);
   assign cpu_in_mmio = addr_fromCPU[SIZE-1:4] == MMIO_BASE[SIZE-1:4];
   assign mmio_off    = addr_fromCPU[3:0];
   assign cpu_wr      = (state == RUN) && wrEn;

   // Single RAM write port shared by the loader (LOAD only) and the CPU (RUN only).
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = ld_addr[AW-1:0];
      ram_wdata = ld_data;
      if (state == LOAD && ld_valid && ld_ready && ld_in_ram) begin
         ram_we = 1'b1;
      end else if (cpu_wr && cpu_in_ram) begin
         ram_we    = 1'b1;
         ram_waddr = addr_fromCPU[AW-1:0];
         ram_wdata = data_fromCPU;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we)
         mem[ram_waddr] <= ram_wdata;
   end

   always_comb begin
      rd_data = '0;
      if (cpu_in_ram) begin
         rd_data = mem[addr_fromCPU[AW-1:0]];
      end else if (cpu_in_mmio) begin
         case (mmio_off)
            4'd0:    rd_data = out_reg;
            4'd1:    rd_data = cycle_cnt;
            4'd2:    rd_data = wr_cnt;
            default: rd_data = '0;
         endcase
      end
   end

   // Read data is sampled before this edge's write lands, giving read-first behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= LOAD;
         data_toCPU <= '0;
         out_reg    <= '0;
         cycle_cnt  <= '0;
         wr_cnt     <= '0;
         cpu_rst    <= 1'b1;
         ld_ready   <= 1'b1;
         halted     <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               data_toCPU <= '0;
               if (ld_done) begin
                  state    <= RUN;
                  cpu_rst  <= 1'b0;
                  ld_ready <= 1'b0;
               end
            end
            RUN: begin
               data_toCPU <= rd_data;
               if (cycle_cnt != '1)
                  cycle_cnt <= cycle_cnt + 32'd1;
               if (cpu_wr && cpu_in_ram && wr_cnt != '1)
                  wr_cnt <= wr_cnt + 32'd1;
               if (cpu_wr && cpu_in_mmio && mmio_off == 4'd0)
                  out_reg <= data_fromCPU;
               if (cpu_wr && cpu_in_mmio && mmio_off == 4'd3) begin
                  state   <= HALT;
                  cpu_rst <= 1'b1;
                  halted  <= 1'b1;
               end
            end
            HALT: begin
               data_toCPU <= '0;
            end
            default: begin
               state      <= LOAD;
               data_toCPU <= '0;
               cpu_rst    <= 1'b1;
               ld_ready   <= 1'b1;
               halted     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// Scoreboard bench for vscpu_mem_responder: a behavioural model predicts read data
// and control outputs for every cycle of a load / run / halt / reset sequence.
module tb_vscpu_mem_responder;

   localparam logic [13:0] MMIO = 14'h3FF0;

   typedef enum int {M_LOAD, M_RUN, M_HALT} mstate_t;

   logic        clk;
   logic        rst;
   logic [13:0] addr_fromCPU;
   logic [31:0] data_fromCPU;
   logic        wrEn;
   logic [31:0] data_toCPU;
   logic        ld_valid;
   logic        ld_ready;
   logic [13:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_done;
   logic        cpu_rst;
   logic [31:0] out_reg;
   logic        halted;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb_q[$];
   logic [31:0] model_mem [1024];
   mstate_t     mstate;
   logic [31:0] m_out;
   logic [31:0] m_cyc;
   logic [31:0] m_wr;

   vscpu_mem_responder dut (
      .clk(clk), .rst(rst),
      .addr_fromCPU(addr_fromCPU), .data_fromCPU(data_fromCPU), .wrEn(wrEn),
      .data_toCPU(data_toCPU),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
      .ld_data(ld_data), .ld_done(ld_done),
      .cpu_rst(cpu_rst), .out_reg(out_reg), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] readModel(input logic [13:0] a);
      if (a < 14'd1024) return model_mem[a[9:0]];
      if (a[13:4] == MMIO[13:4]) begin
         case (a[3:0])
            4'd0:    return m_out;
            4'd1:    return m_cyc;
            4'd2:    return m_wr;
            default: return 32'd0;
         endcase
      end
      return 32'd0;
   endfunction

   task automatic checkControls(input string when);
      checkOutput({when, ".cpu_rst"},  {31'd0, cpu_rst},  {31'd0, mstate != M_RUN});
      checkOutput({when, ".ld_ready"}, {31'd0, ld_ready}, {31'd0, mstate == M_LOAD});
      checkOutput({when, ".halted"},   {31'd0, halted},   {31'd0, mstate == M_HALT});
      checkOutput({when, ".out_reg"},  out_reg, m_out);
   endtask

   // One clock cycle: drive inputs, predict, advance the model, then compare after the edge.
   task automatic applyStimulus(input logic [13:0] a, input logic [31:0] wd, input logic we,
                                input logic lv, input logic [13:0] la, input logic [31:0] ldat,
                                input logic ldn);
      logic [31:0] got;
      addr_fromCPU = a;  data_fromCPU = wd; wrEn = we;
      ld_valid = lv; ld_addr = la; ld_data = ldat; ld_done = ldn;
      sb_q.push_back((mstate == M_RUN) ? readModel(a) : 32'd0);
      case (mstate)
         M_LOAD: begin
            if (lv && la < 14'd1024) model_mem[la[9:0]] = ldat;
            if (ldn) mstate = M_RUN;
         end
         M_RUN: begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (we && a < 14'd1024) begin
               model_mem[a[9:0]] = wd;
               if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
            end
            if (we && a == MMIO) m_out = wd;
            if (we && a == MMIO + 14'd3) mstate = M_HALT;
         end
         default: ;
      endcase
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         got = sb_q.pop_front();
         checkOutput("data_toCPU", data_toCPU, got);
      end
      checkControls("cycle");
   endtask

   task automatic cpu(input logic [13:0] a, input logic [31:0] wd, input logic we);
      applyStimulus(a, wd, we, 1'b0, 14'd0, 32'd0, 1'b0);
   endtask

   // Asserts reset between edges and checks that outputs respond without a clock.
   task automatic doReset();
      rst = 1'b1;
      #1;
      mstate = M_LOAD; m_out = 0; m_cyc = 0; m_wr = 0;
      checkControls("async_rst");
      checkOutput("async_rst.data_toCPU", data_toCPU, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      addr_fromCPU = '0; data_fromCPU = '0; wrEn = 1'b0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
      mstate = M_LOAD; m_out = 0; m_cyc = 0; m_wr = 0;
      for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      checkControls("reset");
      checkOutput("reset.data_toCPU", data_toCPU, 32'd0);
      rst = 1'b0;

      // Load three words; an out-of-range loader word and a CPU write in LOAD must be dropped.
      applyStimulus(14'd0, 32'd0, 1'b0, 1'b1, 14'd0, 32'h1000_4002, 1'b0);
      applyStimulus(14'd0, 32'd0, 1'b0, 1'b1, 14'd1, 32'd5, 1'b0);
      applyStimulus(14'd0, 32'h55, 1'b1, 1'b1, 14'd2000, 32'hDEAD_0000, 1'b0);
      applyStimulus(14'd0, 32'd0, 1'b0, 1'b1, 14'd2, 32'd7, 1'b1);

      cpu(14'd1, 0, 0);
      cpu(14'd2000, 0, 0);
      cpu(14'd0, 0, 0);
      cpu(14'd2, 32'd9, 1);
      cpu(14'd2, 0, 0);
      cpu(MMIO, 32'hDEAD_BEEF, 1);
      cpu(14'd1, 32'd11, 1);
      cpu(MMIO + 14'd2, 0, 0);
      cpu(MMIO, 0, 0);
      cpu(MMIO + 14'd5, 32'd123, 1);
      cpu(MMIO + 14'd1, 0, 0);
      cpu(MMIO + 14'd5, 0, 0);
      cpu(MMIO + 14'd3, 0, 0);
      cpu(MMIO + 14'd3, 0, 1);
      cpu(14'd1, 32'd99, 1);
      cpu(14'd1, 0, 0);
      cpu(MMIO, 32'h1234, 1);

      doReset();
      applyStimulus(14'd0, 0, 0, 1'b0, 14'd0, 32'd0, 1'b1);
      cpu(14'd1, 0, 0);
      cpu(MMIO, 32'hCAFE, 1);
      cpu(MMIO + 14'd1, 0, 0);
      cpu(14'd2, 0, 0);

      doReset();
      applyStimulus(14'd0, 0, 0, 1'b0, 14'd0, 32'd0, 1'b1);
      cpu(14'd1, 0, 0);
      cpu(MMIO + 14'd1, 0, 0);
      cpu(MMIO + 14'd2, 0, 0);
      cpu(14'd0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vscpu_mem_responder.md
Name: vscpu_mem_responder

Overview:
- Responder end of the VerySimpleCPU memory interface: word RAM plus memory-mapped registers.
- Also contains a host program loader that holds the CPU in reset while an external host fills RAM.
- Sits between the CPU core and the top level.
- The CPU's addr_toRAM, data_toRAM and wrEn drive this block's inputs; data_toCPU drives the CPU's data_fromRAM.

Parameters:
- SIZE, 14, address width (matches CPU SIZE).
- MEM_DEPTH, 1024, RAM words backing addresses 0..MEM_DEPTH-1.
- MMIO_BASE, 14'h3FF0, base of the 16-word MMIO region (MMIO_BASE..MMIO_BASE+15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_fromCPU  in  SIZE  CPU word address.
- data_fromCPU  in  32  CPU write data.
- wrEn  in  1  CPU write strobe.
- data_toCPU  out  32  registered read data.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader may transfer.
- ld_addr  in  SIZE  loader word address.
- ld_data  in  32  loader word data.
- ld_done  in  1  loader finished (1-cycle pulse).
- cpu_rst  out  1  reset to CPU core.
- out_reg  out  32  OUT register value.
- halted  out  1  CPU halted.

Behaviour:
- Reset (async, rst=1):
  - state=LOAD; data_toCPU=0, out_reg=0, cycle_cnt=0, wr_cnt=0.
  - cpu_rst=1, ld_ready=1, halted=0.
  - RAM contents are not reset.
- States and transitions:
  - LOAD: cpu_rst=1, ld_ready=1. ld_done=1 moves to RUN next cycle.
  - RUN: cpu_rst=0, ld_ready=0. A CPU write to MMIO_BASE+3 moves to HALT next cycle.
  - HALT: cpu_rst=1, halted=1. Exit only by rst.
- All outputs are registered from state, with no combinational input-to-output paths.
- Loader:
  - In LOAD, ld_valid&&ld_ready writes ld_data into RAM[ld_addr] when ld_addr<MEM_DEPTH; other addresses are dropped.
  - ld_valid and ld_done in the same cycle: the word is written, then RUN.
  - ld_valid outside LOAD is ignored.
- CPU reads, RUN only:
  - data_toCPU at edge N+1 equals the content of addr_fromCPU sampled at edge N (latency 1).
  - This matches the CPU presenting an address in one state and consuming data_fromRAM in the next.
  - In LOAD/HALT, data_toCPU is held at 0.
- CPU writes, RUN only, wrEn=1:
  - Address <MEM_DEPTH: RAM write.
  - MMIO address: register write.
  - Otherwise: ignored.
  - Read and write in the same cycle are read-first: data_toCPU returns the old content.
  - CPU writes are ignored in LOAD and HALT.
- Address decode:
  - addr<MEM_DEPTH: RAM.
  - MMIO_BASE<=addr<=MMIO_BASE+15: MMIO.
  - Else: reads return 0.
- MMIO map (offset):
  - 0 OUT: R/W, drives out_reg.
  - 1 CYCLE_CNT: RO. +1 every RUN cycle, saturates at 32'hFFFFFFFF, frozen in HALT. A read returns the value at the address-sample edge.
  - 2 WR_CNT: RO. +1 per RUN-state RAM write (MMIO writes not counted), saturating.
  - 3 HALT: WO, any write halts. Reads 0.
  - 4-15: read 0, writes ignored.
- Arithmetic: counters are 32-bit unsigned. The RAM index uses addr_fromCPU directly, with no wrap.
- rst asserted mid-RUN: immediate return to LOAD with counters cleared. RAM is retained, so a re-run needs no reload (ld_done alone restarts).

Test Plan:
- Reset then load 3 words: ld RAM[0]=32'h1000_4002, RAM[1]=5, RAM[2]=7, then ld_done. Required: cpu_rst falls 1 cycle after ld_done; ld_ready=0 thereafter.
- Read latency: in RUN present addr 1 at edge N. Required: data_toCPU=5 after edge N+1; addr 2000 (unmapped) returns 0.
- Read-first: write 9 to addr 2 while reading addr 2 the same cycle. Required: data_toCPU=7 next cycle, then 9 on the following read.
- MMIO: write 32'hDEAD_BEEF to MMIO_BASE. Required: out_reg=32'hDEADBEEF. Two RAM writes required: WR_CNT reads 2. CYCLE_CNT read at RUN cycle 10 returns 10.
- Halt: write 0 to MMIO_BASE+3. Required:
  - halted=1 and cpu_rst=1 next cycle.
  - Subsequent wrEn to addr 1 leaves RAM[1] unchanged.
  - CYCLE_CNT frozen.
- Async reset mid-RUN: assert rst between edges. Required: cpu_rst=1 and out_reg=0 immediately; after ld_done with no new loads, RAM[1] still reads back its last written value.
